locked_adder_key_sweep_ctrl: RTL and testbench
==============================================

// Module: locked_adder_key_sweep_ctrl
// PURPOSE
//  Sequences key-evaluation jobs for the XOR-locked 32-bit segmented adder (64-bit key). Per job: latches one
//  candidate key, drives NUM_VEC pseudo-random operand pairs into the adder, samples result after a settle window,
//  checks it against the true 33-bit sum. Reports the mismatch count and first failing vector index over a valid/ready
//  handshake. Sits between the key-search host and the combinational locked adder netlist.
// PARAMETERS
//  NUM_VEC        16   operand pairs per job; 1..2**IDX_W-1
//  SETTLE_CYCLES  2    clocks between operand update and result sampling; >=1
//  IDX_W          8    width of vector index / first-fail index
//  CNT_W          8    width of mismatch counter (saturating)
// PORTS
//  clk_i                 in   1      clock
//  rst_ni                in   1      synchronous, active-low reset
//  key_valid_i           in   1      candidate key offered
//  key_ready_o           out  1      controller accepts a key (IDLE only)
//  key_i                 in   64     candidate key
//  seed_i                in   32     operand LFSR seed, sampled with key
//  dut_add1_o            out  32     operand A to locked adder
//  dut_add2_o            out  32     operand B to locked adder
//  dut_key_o             out  64     key to locked adder
//  dut_result_i          in   33     locked adder sum
//  res_valid_o           out  1      job result available
//  res_ready_i           in   1      host consumes result
//  res_key_o             out  64     key the result belongs to
//  res_err_cnt_o         out  CNT_W  mismatching vectors (saturating)
//  res_first_fail_o      out  IDX_W  index of first mismatch; all-ones if none
//  res_pass_o            out  1      1 iff res_err_cnt_o==0
// BEHAVIOUR
//  Clock/reset: single clk_i; reset is synchronous and active-low on rst_ni. All outputs reset to 0 except
//   key_ready_o=1 and res_first_fail_o=all-ones. rst_ni low mid-job discards the job and forces IDLE next edge.
//  FSM: IDLE -> APPLY -> SETTLE -> CHECK -> (APPLY | REPORT) -> IDLE.
//   IDLE:   key_ready_o=1. On key_valid_i: latch key_i into dut_key_o/res_key_o, load LFSR_A=seed_i,
//           LFSR_B=seed_i^32'h5A5A_5A5A (zero state replaced by 32'h1), vec_idx=0, err_cnt=0,
//           first_fail=all-ones -> APPLY.
//   APPLY:  1 cycle; register dut_add1_o=LFSR_A, dut_add2_o=LFSR_B; load settle_cnt=SETTLE_CYCLES-1 -> SETTLE.
//   SETTLE: operands and key held stable; decrement settle_cnt; at 0 -> CHECK.
//   CHECK:  1 cycle; mismatch = dut_result_i != {1'b0,dut_add1_o}+{1'b0,dut_add2_o}. On mismatch err_cnt++
//           (saturates at 2**CNT_W-1); first_fail=vec_idx if still all-ones. vec_idx==NUM_VEC-1 -> REPORT, else
//           vec_idx++, advance both LFSRs one step -> APPLY.
//   REPORT: res_valid_o=1, result fields stable until res_valid_o&&res_ready_i; then IDLE.
//           key_ready_o=0 here: keys offered during REPORT stall; no same-cycle REPORT->accept.
//  LFSR: 32-bit Galois, taps 32'h8020_0003, right-shift; one step per vector.
//  Latency: accept to res_valid_o = NUM_VEC*(SETTLE_CYCLES+2) cycles (defaults: 64).
//  dut_* outputs hold last values in IDLE/REPORT; dut_key_o changes only on key accept.
//  dut_result_i sampled only in CHECK; X/glitches during APPLY/SETTLE ignored.
// STRUCTURE
//  Package lasc_pkg: state enum (IDLE,APPLY,SETTLE,CHECK,REPORT), LFSR_TAPS, B_SEED_XOR, KEY_W=64, OP_W=32.
//  Sub-module lasc_lfsr32 (load, step, state out), instantiated twice; FSM, counters, compare in top.
// TESTING
//  1 Stub adder = true sum (ignores key), key 64'hB4503A5DF07C268F, seed 32'h1 -> after 64 cycles res_valid_o,
//    err_cnt=0, first_fail=8'hFF, pass=1, res_key_o echoes key.
//  2 Stub = sum^33'h1 always -> err_cnt=16, first_fail=0, pass=0.
//  3 Stub corrupts only 6th CHECK sample -> err_cnt=1, first_fail=5; CNT_W=2 and always-wrong stub -> err_cnt=3.
//  4 res_ready_i low 10 cycles, key_valid_i high meanwhile -> result fields stable, key_ready_o=0; ready pulse
//    -> IDLE, new key accepted the following cycle.
//  5 seed_i=32'h5A5A_5A5A -> LFSR_B zero-replaced by 32'h1; operands match bench LFSR model every vector.
//  6 rst_ni low at vector 7 -> next edge IDLE, key_ready_o=1, res_valid_o=0; fresh job yields results as case 1.

Source files
------------

// File: rtl/locked_adder_key_sweep_ctrl_pkg.sv
// Shared constants, state encodings and the LFSR step function for the
// locked-adder key sweep controller.
package lasc_pkg;

    localparam int KEY_W = 64;
    localparam int OP_W  = 32;

    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic [31:0] B_SEED_XOR = 32'h5A5A_5A5A;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_APPLY  = 3'd1;
    localparam state_t ST_SETTLE = 3'd2;
    localparam state_t ST_CHECK  = 3'd3;
    localparam state_t ST_REPORT = 3'd4;

    // Galois right-shift: the bit shifted out selects whether the taps are folded back in.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/locked_adder_key_sweep_ctrl_if.sv
// Host-side key request / job result handshake bundle of the key sweep controller.
interface locked_adder_key_sweep_ctrl_if #(
    parameter int IDX_W = 8,
    parameter int CNT_W = 8
);
    logic                      key_valid_i;
    logic                      key_ready_o;
    logic [lasc_pkg::KEY_W-1:0] key_i;
    logic [lasc_pkg::OP_W-1:0]  seed_i;
    logic                      res_valid_o;
    logic                      res_ready_i;
    logic [lasc_pkg::KEY_W-1:0] res_key_o;
    logic [CNT_W-1:0]          res_err_cnt_o;
    logic [IDX_W-1:0]          res_first_fail_o;
    logic                      res_pass_o;

    modport slave (
        input  key_valid_i, key_i, seed_i, res_ready_i,
        output key_ready_o, res_valid_o, res_key_o, res_err_cnt_o, res_first_fail_o, res_pass_o
    );

    modport master (
        output key_valid_i, key_i, seed_i, res_ready_i,
        input  key_ready_o, res_valid_o, res_key_o, res_err_cnt_o, res_first_fail_o, res_pass_o
    );
endinterface

// File: rtl/locked_adder_key_sweep_ctrl_lfsr.sv
// 32-bit Galois LFSR operand generator; load has priority over step.
module lasc_lfsr32
    import lasc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] seed_i,
    output logic [31:0] state_o
);
    logic [31:0] state_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= 32'h1;
        end else if (load_i) begin
            state_q <= seed_i;
        end else if (step_i) begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign state_o = state_q;
endmodule

// File: rtl/locked_adder_key_sweep_ctrl.sv
// Runs one candidate key against the locked adder over NUM_VEC LFSR operand pairs
// and reports the mismatch count and first failing vector index.
module locked_adder_key_sweep_ctrl
    import lasc_pkg::*;
#(
    parameter int NUM_VEC       = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int IDX_W         = 8,
    parameter int CNT_W         = 8
)(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    locked_adder_key_sweep_ctrl_if.slave host,
    output logic [OP_W-1:0]        dut_add1_o,
    output logic [OP_W-1:0]        dut_add2_o,
    output logic [KEY_W-1:0]       dut_key_o,
    input  logic [OP_W:0]          dut_result_i
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  vec_idx_q, vec_idx_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [IDX_W-1:0]  first_fail_q, first_fail_d;
    logic              pass_q, pass_d;
    logic [OP_W-1:0]   add1_q, add1_d, add2_q, add2_d;
    logic [KEY_W-1:0]  key_q, key_d;

    logic              lfsr_load, lfsr_step;
    logic [OP_W-1:0]   lfsr_a, lfsr_b, seed_b;
    logic              mismatch;

    // An all-zero Galois state never leaves zero, so the B seed is patched to 1.
    assign seed_b   = ((host.seed_i ^ B_SEED_XOR) == 32'h0) ? 32'h1 : (host.seed_i ^ B_SEED_XOR);
    assign mismatch = dut_result_i != ({1'b0, add1_q} + {1'b0, add2_q});

    lasc_lfsr32 u_lfsr_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .load_i(lfsr_load), .step_i(lfsr_step),
        .seed_i(host.seed_i), .state_o(lfsr_a)
    );

    lasc_lfsr32 u_lfsr_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .load_i(lfsr_load), .step_i(lfsr_step),
        .seed_i(seed_b), .state_o(lfsr_b)
    );

    always_comb begin
        state_d      = state_q;
        vec_idx_d    = vec_idx_q;
        settle_d     = settle_q;
        err_d        = err_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;
        add1_d       = add1_q;
        add2_d       = add2_q;
        key_d        = key_q;
        lfsr_load    = 1'b0;
        lfsr_step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (host.key_valid_i) begin
                    key_d        = host.key_i;
                    vec_idx_d    = '0;
                    err_d        = '0;
                    first_fail_d = '1;
                    pass_d       = 1'b0;
                    lfsr_load    = 1'b1;
                    state_d      = ST_APPLY;
                end
            end
            ST_APPLY: begin
                add1_d   = lfsr_a;
                add2_d   = lfsr_b;
                settle_d = SW'(SETTLE_CYCLES - 1);
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == '0) state_d = ST_CHECK;
                else                settle_d = settle_q - SW'(1);
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (err_q != '1)        err_d = err_q + CNT_W'(1);
                    if (first_fail_q == '1) first_fail_d = vec_idx_q;
                end
                if (vec_idx_q == IDX_W'(NUM_VEC - 1)) begin
                    pass_d  = (err_d == '0);
                    state_d = ST_REPORT;
                end else begin
                    vec_idx_d = vec_idx_q + IDX_W'(1);
                    lfsr_step = 1'b1;
                    state_d   = ST_APPLY;
                end
            end
            ST_REPORT: begin
                if (host.res_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            vec_idx_q    <= '0;
            settle_q     <= '0;
            err_q        <= '0;
            first_fail_q <= '1;
            pass_q       <= 1'b0;
            add1_q       <= '0;
            add2_q       <= '0;
            key_q        <= '0;
        end else begin
            state_q      <= state_d;
            vec_idx_q    <= vec_idx_d;
            settle_q     <= settle_d;
            err_q        <= err_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
            add1_q       <= add1_d;
            add2_q       <= add2_d;
            key_q        <= key_d;
        end
    end

    assign host.key_ready_o      = (state_q == ST_IDLE);
    assign host.res_valid_o      = (state_q == ST_REPORT);
    assign host.res_key_o        = key_q;
    assign host.res_err_cnt_o    = err_q;
    assign host.res_first_fail_o = first_fail_q;
    assign host.res_pass_o       = pass_q;
    assign dut_add1_o            = add1_q;
    assign dut_add2_o            = add2_q;
    assign dut_key_o             = key_q;
endmodule

// File: tb/tb_locked_adder_key_sweep_ctrl.sv
// Scoreboard bench for the key sweep controller using a stub adder with selectable corruption.
module tb_locked_adder_key_sweep_ctrl;

    localparam logic [63:0] KEY1 = 64'hB450_3A5D_F07C_268F;

    typedef struct {
        logic [63:0] key;
        logic [7:0]  errCnt;
        logic [7:0]  firstFail;
        logic        pass;
    } expT;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    locked_adder_key_sweep_ctrl_if #(.IDX_W(8), .CNT_W(8)) hostIf ();
    locked_adder_key_sweep_ctrl_if #(.IDX_W(8), .CNT_W(2)) hostIf2 ();

    logic [31:0] dutAdd1, dutAdd2, dutAdd1b, dutAdd2b;
    logic [63:0] dutKey, dutKeyB;
    logic [32:0] dutResult, dutResultB;

    int          stubMode = 0;
    logic [31:0] corruptA = 32'h0;

    // Mode 1 corrupts every sample, mode 2 only the vector whose A operand is corruptA.
    always_comb begin
        dutResult = ({1'b0, dutAdd1} + {1'b0, dutAdd2})
                  ^ (((stubMode == 1) || (stubMode == 2 && dutAdd1 == corruptA)) ? 33'h1 : 33'h0);
        dutResultB = ({1'b0, dutAdd1b} + {1'b0, dutAdd2b}) ^ 33'h1;
    end

    locked_adder_key_sweep_ctrl #(.NUM_VEC(16), .SETTLE_CYCLES(2), .IDX_W(8), .CNT_W(8)) u_dut (
        .clk_i(clk), .rst_ni(rstN), .host(hostIf),
        .dut_add1_o(dutAdd1), .dut_add2_o(dutAdd2), .dut_key_o(dutKey), .dut_result_i(dutResult)
    );

    locked_adder_key_sweep_ctrl #(.NUM_VEC(16), .SETTLE_CYCLES(2), .IDX_W(8), .CNT_W(2)) u_dut_sat (
        .clk_i(clk), .rst_ni(rstN), .host(hostIf2),
        .dut_add1_o(dutAdd1b), .dut_add2_o(dutAdd2b), .dut_key_o(dutKeyB), .dut_result_i(dutResultB)
    );

    int  testsRun = 0;
    int  testsFailed = 0;
    expT expQ[$];
    expT expQ2[$];
    expT lastExp;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] modelStep(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    // Drives one job, checks operands per vector and the 64-cycle latency, then scoreboards the result.
    task automatic applyStimulus(input logic [63:0] key, input logic [31:0] seed, input int mode,
                                 input bit checkOps);
        logic [31:0] a, b;
        logic [31:0] opsA[16], opsB[16];
        int errs, ff, guard;
        expT e, got;
        a = seed;
        b = seed ^ 32'h5A5A_5A5A;
        if (b == 32'h0) b = 32'h1;
        errs = 0;
        ff = 255;
        for (int v = 0; v < 16; v++) begin
            opsA[v] = a;
            opsB[v] = b;
            if (mode == 1 || (mode == 2 && v == 5)) begin
                errs++;
                if (ff == 255) ff = v;
            end
            a = modelStep(a);
            b = modelStep(b);
        end
        corruptA = opsA[5];
        stubMode = mode;
        e.key = key;
        e.errCnt = 8'(errs);
        e.firstFail = 8'(ff);
        e.pass = (errs == 0);
        expQ.push_back(e);
        lastExp = e;

        guard = 0;
        while (!hostIf.key_ready_o && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput("keyReadyIdle", 64'(hostIf.key_ready_o), 64'h1);
        hostIf.key_valid_i = 1'b1;
        hostIf.key_i = key;
        hostIf.seed_i = seed;
        tick();
        hostIf.key_valid_i = 1'b0;
        checkOutput("dutKeyLatched", dutKey, key);

        for (int c = 1; c <= 64; c++) begin
            tick();
            if (checkOps && ((c - 1) % 4 == 0)) begin
                checkOutput($sformatf("opA[%0d]", (c - 1) / 4), 64'(dutAdd1), 64'(opsA[(c - 1) / 4]));
                checkOutput($sformatf("opB[%0d]", (c - 1) / 4), 64'(dutAdd2), 64'(opsB[(c - 1) / 4]));
            end
            if (c == 63) checkOutput("resValidEarly", 64'(hostIf.res_valid_o), 64'h0);
        end
        checkOutput("resValidLatency", 64'(hostIf.res_valid_o), 64'h1);
        if (hostIf.res_valid_o && expQ.size() > 0) begin
            got = expQ.pop_front();
            checkOutput("resKey", hostIf.res_key_o, got.key);
            checkOutput("resErrCnt", 64'(hostIf.res_err_cnt_o), 64'(got.errCnt));
            checkOutput("resFirstFail", 64'(hostIf.res_first_fail_o), 64'(got.firstFail));
            checkOutput("resPass", 64'(hostIf.res_pass_o), 64'(got.pass));
        end
    endtask

    // Consumes the result; with a stall, offers altKey meanwhile and leaves that job running.
    task automatic finishJob(input int stall, input logic [63:0] altKey);
        bit stable;
        stable = 1'b1;
        if (stall > 0) begin
            hostIf.key_valid_i = 1'b1;
            hostIf.key_i = altKey;
            hostIf.seed_i = 32'h1234_5678;
            for (int i = 0; i < stall; i++) begin
                tick();
                if (hostIf.key_ready_o !== 1'b0 || hostIf.res_valid_o !== 1'b1 ||
                    hostIf.res_key_o !== lastExp.key || hostIf.res_err_cnt_o !== lastExp.errCnt ||
                    hostIf.res_first_fail_o !== lastExp.firstFail || hostIf.res_pass_o !== lastExp.pass)
                    stable = 1'b0;
            end
            checkOutput("stallStable", 64'(stable), 64'h1);
        end
        hostIf.res_ready_i = 1'b1;
        tick();
        hostIf.res_ready_i = 1'b0;
        checkOutput("idleReady", 64'(hostIf.key_ready_o), 64'h1);
        checkOutput("idleNoValid", 64'(hostIf.res_valid_o), 64'h0);
        if (stall > 0) begin
            tick();
            hostIf.key_valid_i = 1'b0;
            checkOutput("nextAcceptBusy", 64'(hostIf.key_ready_o), 64'h0);
            checkOutput("nextAcceptKey", dutKey, altKey);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        expT e2, got2;
        hostIf.key_valid_i = 1'b0;
        hostIf.key_i = '0;
        hostIf.seed_i = '0;
        hostIf.res_ready_i = 1'b0;
        hostIf2.key_valid_i = 1'b0;
        hostIf2.key_i = '0;
        hostIf2.seed_i = '0;
        hostIf2.res_ready_i = 1'b0;

        repeat (3) tick();
        checkOutput("rstKeyReady", 64'(hostIf.key_ready_o), 64'h1);
        checkOutput("rstResValid", 64'(hostIf.res_valid_o), 64'h0);
        checkOutput("rstFirstFail", 64'(hostIf.res_first_fail_o), 64'hFF);
        checkOutput("rstErrCnt", 64'(hostIf.res_err_cnt_o), 64'h0);
        checkOutput("rstPass", 64'(hostIf.res_pass_o), 64'h0);
        checkOutput("rstDutKey", dutKey, 64'h0);
        checkOutput("rstDutAdd1", 64'(dutAdd1), 64'h0);
        rstN = 1'b1;
        tick();

        applyStimulus(KEY1, 32'h1, 0, 1'b1);
        finishJob(0, 64'h0);
        applyStimulus(64'h0123_4567_89AB_CDEF, 32'hDEAD_BEEF, 1, 1'b0);
        finishJob(0, 64'h0);
        applyStimulus(64'hFEDC_BA98_7654_3210, 32'hC0FF_EE11, 2, 1'b1);
        finishJob(0, 64'h0);
        applyStimulus(64'h1111_2222_3333_4444, 32'h5A5A_5A5A, 0, 1'b1);
        finishJob(10, 64'hAAAA_5555_AAAA_5555);

        // Abort the job accepted above while it works on vector 7.
        repeat (29) tick();
        rstN = 1'b0;
        tick();
        checkOutput("abortKeyReady", 64'(hostIf.key_ready_o), 64'h1);
        checkOutput("abortResValid", 64'(hostIf.res_valid_o), 64'h0);
        rstN = 1'b1;
        tick();
        applyStimulus(KEY1, 32'h1, 0, 1'b1);
        finishJob(0, 64'h0);

        e2.key = 64'h7777_8888_9999_AAAA;
        e2.errCnt = 8'd3;
        e2.firstFail = 8'd0;
        e2.pass = 1'b0;
        expQ2.push_back(e2);
        hostIf2.key_valid_i = 1'b1;
        hostIf2.key_i = e2.key;
        hostIf2.seed_i = 32'h0BAD_F00D;
        tick();
        hostIf2.key_valid_i = 1'b0;
        guard = 0;
        while (!hostIf2.res_valid_o && guard < 200) begin
            tick();
            guard++;
        end
        checkOutput("satResValid", 64'(hostIf2.res_valid_o), 64'h1);
        if (hostIf2.res_valid_o && expQ2.size() > 0) begin
            got2 = expQ2.pop_front();
            checkOutput("satErrCnt", 64'(hostIf2.res_err_cnt_o), 64'(got2.errCnt));
            checkOutput("satFirstFail", 64'(hostIf2.res_first_fail_o), 64'(got2.firstFail));
            checkOutput("satPass", 64'(hostIf2.res_pass_o), 64'(got2.pass));
            checkOutput("satKey", hostIf2.res_key_o, got2.key);
        end
        hostIf2.res_ready_i = 1'b1;
        tick();
        hostIf2.res_ready_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
